// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: receives PS/2 frames and tracks the currently held make code.
// Ports:
//   clk, rst_n        system clock (rising edge) and async active-low reset
//   ps2_clk, ps2_data raw PS/2 lines, asynchronous to clk
//   key_code          last accepted make code
//   key_valid         high while key_code is held down
//   byte_strb         one-cycle pulse per correctly received byte
//   frame_err         one-cycle pulse on parity or stop-bit failure
module ps2_key_tracker #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       byte_strb,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_clk_f, r_clk_f_d;
    logic [FW-1:0]   r_flt_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic            r_brk;
    logic [7:0]      r_code;
    logic            r_valid, r_strb, r_err;
    logic            w_fall, w_to_hit, w_stop_edge, w_good;

    assign w_fall      = r_clk_f_d & ~r_clk_f;
    assign w_to_hit    = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_stop_edge = (r_state == STOP) && w_fall;
    assign w_good      = r_dat_s2 & ^{r_shift, r_par};

    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign byte_strb = r_strb;
    assign frame_err = r_err;

    // Synchronizers and the glitch filter on the PS/2 clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_clk_s1  <= ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= ps2_data;
            r_dat_s2  <= r_dat_s1;
            r_clk_f_d <= r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_f   <= ~r_clk_f;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (w_fall && !r_dat_s2) ? DATA : IDLE;
            DATA:    w_state_nxt = (w_fall && r_bit_cnt == 3'd7) ? PARITY : DATA;
            PARITY:  w_state_nxt = w_fall ? STOP : PARITY;
            default: w_state_nxt = w_fall ? IDLE : STOP;
        endcase
        // An edge in the same cycle as the timeout takes priority
        if (r_state != IDLE && !w_fall && w_to_hit) w_state_nxt = IDLE;
    end

    // Frame datapath, inter-edge timeout counter and key tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_brk     <= 1'b0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_strb    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_to_cnt  <= (r_state == IDLE || w_fall || w_to_hit) ? '0 : r_to_cnt + 1'b1;
            r_bit_cnt <= (r_state != DATA) ? 3'd0 : r_bit_cnt + 3'(w_fall);
            if (r_state == DATA && w_fall) r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_state == PARITY && w_fall) r_par <= r_dat_s2;
            r_strb <= w_stop_edge & w_good;
            r_err  <= w_stop_edge & ~w_good;
            if (w_stop_edge && w_good) begin
                if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (r_shift != 8'hE0) begin
                    if (r_brk) begin
                        r_brk <= 1'b0;
                        if (r_shift == r_code) r_valid <= 1'b0;
                    end else begin
                        r_code  <= r_shift;
                        r_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed self-checking bench for ps2_key_tracker.
module tb_ps2_key_tracker;
    localparam int FL = 4;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_valid, byte_strb, frame_err;

    int checks = 0;
    int errors = 0;
    int strb_cnt = 0;
    int err_cnt = 0;
    int s0, e0;

    ps2_key_tracker #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .key_valid(key_valid),
        .byte_strb(byte_strb), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (byte_strb) strb_cnt <= strb_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clk(10);
            ps2_clk = 1'b0;
            wait_clk(15);
            ps2_clk = 1'b1;
            wait_clk(15);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~^b ^ bad_par;
        send_bits({1'b1, p, b, 1'b0}, 11);
        wait_clk(5);
    endtask

    task automatic mark();
        s0 = strb_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        wait_clk(3);
        chk("rst_code", {24'd0, key_code}, 32'h00);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_strb", {31'd0, byte_strb}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        mark();
        send_frame(8'h1C, 1'b0);
        chk("make_strb", strb_cnt - s0, 32'd1);
        chk("make_err", err_cnt - e0, 32'd0);
        chk("make_code", {24'd0, key_code}, 32'h1C);
        chk("make_valid", {31'd0, key_valid}, 32'd1);

        mark();
        send_frame(8'hF0, 1'b0);
        chk("brk_prefix_valid", {31'd0, key_valid}, 32'd1);
        send_frame(8'h1C, 1'b0);
        chk("brk_strb", strb_cnt - s0, 32'd2);
        chk("brk_valid", {31'd0, key_valid}, 32'd0);
        chk("brk_code", {24'd0, key_code}, 32'h1C);

        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        chk("other_brk_valid", {31'd0, key_valid}, 32'd1);
        chk("other_brk_code", {24'd0, key_code}, 32'h1C);
        send_frame(8'h1C, 1'b0);
        chk("pending_clear_valid", {31'd0, key_valid}, 32'd1);
        chk("pending_clear_code", {24'd0, key_code}, 32'h1C);

        mark();
        send_frame(8'h29, 1'b1);
        chk("par_err", err_cnt - e0, 32'd1);
        chk("par_strb", strb_cnt - s0, 32'd0);
        chk("par_code", {24'd0, key_code}, 32'h1C);
        chk("par_valid", {31'd0, key_valid}, 32'd1);

        mark();
        send_bits(11'b00_0000_1010_0, 5);
        wait_clk(TO + 50);
        send_frame(8'h32, 1'b0);
        chk("to_err", err_cnt - e0, 32'd0);
        chk("to_strb", strb_cnt - s0, 32'd1);
        chk("to_code", {24'd0, key_code}, 32'h32);
        chk("to_valid", {31'd0, key_valid}, 32'd1);

        mark();
        send_frame(8'hE0, 1'b0);
        chk("ext_strb", strb_cnt - s0, 32'd1);
        chk("ext_code", {24'd0, key_code}, 32'h32);

        mark();
        ps2_data = 1'b0;
        wait_clk(2);
        ps2_clk = 1'b0;
        wait_clk(FL - 1);
        ps2_clk = 1'b1;
        wait_clk(5);
        ps2_data = 1'b1;
        wait_clk(5);
        send_frame(8'h15, 1'b0);
        chk("glitch_strb", strb_cnt - s0, 32'd1);
        chk("glitch_err", err_cnt - e0, 32'd0);
        chk("glitch_code", {24'd0, key_code}, 32'h15);

        send_bits(11'b00_0110_0110_0, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_code", {24'd0, key_code}, 32'h00);
        chk("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        chk("mid_rst_strb", {31'd0, byte_strb}, 32'd0);
        chk("mid_rst_err", {31'd0, frame_err}, 32'd0);
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(5);
        mark();
        send_frame(8'h25, 1'b0);
        chk("post_rst_strb", strb_cnt - s0, 32'd1);
        chk("post_rst_code", {24'd0, key_code}, 32'h25);
        chk("post_rst_valid", {31'd0, key_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
